spi_reg_bridge: RTL and testbench

SPI slave front end that turns serial host frames into register-bus transactions. It drives the register address, write data and transfer-complete strobe consumed by the trigger generator and the register file. It also fetches read data for the host. The SPI pins are asynchronous to clk; all logic runs in the clk domain using oversampled, synchronised SPI inputs.

---
 rtl/spi_reg_bridge.sv | 263 ++++++++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
//
// SPI mode-0 slave that converts three-byte host frames (CMD, ADDR, DATA)
// into register-bus transactions. All logic runs in the clk domain. The SPI
// pins are synchronised and oversampled, so sclk must stay high and low for
// at least 4 clk periods each.
//
// Frame : CMD  [7]=write(1)/read(0), [6:3] ignored, [2:0]=address[10:8]
//         ADDR address[7:0]
//         DATA write data from the host, or read data returned on miso
//
// Optional build macro SPI_BURST_EN: after each DATA byte the bridge stays in
// DATA and auto-increments the address, so every further byte is one more
// write or read. Without it, bytes after DATA are shifted in and discarded.
//
// Parameters
//   SYNC_STAGES : flip-flops per pin synchroniser (>= 2)
//   ADDR_W      : register address width (at most 11)
//
// Ports
//   clk       in   master clock
//   rst_n     in   asynchronous active-low reset
//   sclk      in   SPI clock, CPOL=0/CPHA=0, asynchronous
//   cs_n      in   SPI chip select, active-low, asynchronous
//   mosi      in   SPI serial data in, MSB first
//   miso      out  SPI serial data out, MSB first
//   rdata     in   register read data, valid the cycle after rd_strobe
//   rd_strobe out  one-cycle read request at the current address
//   address   out  register address
//   wdata     out  register write data
//   xfc       out  one-cycle write transfer-complete pulse
// -----------------------------------------------------------------------------
module spi_reg_bridge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ADDR_W      = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   input  logic [7:0]        rdata,
   output logic              rd_strobe,
   output logic [ADDR_W-1:0] address,
   output logic [7:0]        wdata,
   output logic              xfc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_IGNORE
   } state_e;

   // Pin synchronisers
   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_s, cs_s, mosi_s;

   // Frame state
   state_e            state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              is_write_q, is_write_d;
   logic [2:0]        addr_hi_q, addr_hi_d;

   // Register-bus side
   logic [ADDR_W-1:0] address_q, address_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              wr_pend_q, wr_pend_d;
   logic              xfc_q, xfc_d;
   logic              rd_strobe_q, rd_strobe_d;
   logic              rd_cap_q, rd_cap_d;
   logic [7:0]        miso_sh_q, miso_sh_d;
`ifdef SPI_BURST_EN
   logic              burst_next_q, burst_next_d;
`endif

   logic              rise, fall, cs_fall, last_bit;
   logic [7:0]        byte_val;

   assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];

   assign rise     = sclk_s & ~sclk_prev_q;
   assign fall     = ~sclk_s & sclk_prev_q;
   assign cs_fall  = cs_prev_q & ~cs_s;
   assign last_bit = rise && (bit_cnt_q == 3'd7);
   // Byte as it will look once the bit being sampled this cycle is shifted in
   assign byte_val = {shift_q[6:0], mosi_s};

   // cs_n synchroniser resets low: a reset taken mid-frame with cs_n still
   // asserted must not look like a fresh falling edge once reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q  <= '0;
         cs_sync_q    <= '0;
         mosi_sync_q  <= '0;
         sclk_prev_q  <= 1'b0;
         cs_prev_q    <= 1'b0;
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         is_write_q   <= 1'b0;
         addr_hi_q    <= '0;
         address_q    <= '0;
         wdata_q      <= '0;
         wr_pend_q    <= 1'b0;
         xfc_q        <= 1'b0;
         rd_strobe_q  <= 1'b0;
         rd_cap_q     <= 1'b0;
         miso_sh_q    <= '0;
`ifdef SPI_BURST_EN
         burst_next_q <= 1'b0;
`endif
      end else begin
         sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
         mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sclk_prev_q  <= sclk_s;
         cs_prev_q    <= cs_s;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         is_write_q   <= is_write_d;
         addr_hi_q    <= addr_hi_d;
         address_q    <= address_d;
         wdata_q      <= wdata_d;
         wr_pend_q    <= wr_pend_d;
         xfc_q        <= xfc_d;
         rd_strobe_q  <= rd_strobe_d;
         rd_cap_q     <= rd_cap_d;
         miso_sh_q    <= miso_sh_d;
`ifdef SPI_BURST_EN
         burst_next_q <= burst_next_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      is_write_d   = is_write_q;
      addr_hi_d    = addr_hi_q;
      address_d    = address_q;
      wdata_d      = wdata_q;
      wr_pend_d    = 1'b0;
      xfc_d        = wr_pend_q;
      rd_strobe_d  = 1'b0;
      rd_cap_d     = rd_strobe_q;
      miso_sh_d    = miso_sh_q;
`ifdef SPI_BURST_EN
      burst_next_d = burst_next_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (cs_fall) begin
               state_d   = S_CMD;
               bit_cnt_d = '0;
            end
         end

         S_CMD: begin
            if (rise) begin
               shift_d   = byte_val;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (last_bit) begin
                  is_write_d = byte_val[7];
                  addr_hi_d  = byte_val[2:0];
                  state_d    = S_ADDR;
               end
            end
         end

         S_ADDR: begin
            if (rise) begin
               shift_d   = byte_val;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (last_bit) begin
                  address_d   = ADDR_W'({addr_hi_q, byte_val});
                  rd_strobe_d = ~is_write_q;
                  state_d     = S_DATA;
`ifdef SPI_BURST_EN
                  burst_next_d = 1'b0;
`endif
               end
            end
         end

         S_DATA: begin
            if (rise) begin
               shift_d   = byte_val;
               bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef SPI_BURST_EN
               // Burst writes step the address on the first bit of the next
               // byte, so it stays stable across the previous xfc pulse.
               if (burst_next_q && (bit_cnt_q == 3'd0)) begin
                  address_d    = address_q + ADDR_W'(1);
                  burst_next_d = 1'b0;
               end
`endif
               if (last_bit) begin
                  if (is_write_q) begin
                     wdata_d   = byte_val;
                     wr_pend_d = 1'b1;
                  end
`ifdef SPI_BURST_EN
                  // Burst reads step immediately so the next byte's data is
                  // fetched before its first bit has to leave on miso.
                  if (is_write_q) begin
                     burst_next_d = 1'b1;
                  end else begin
                     address_d   = address_q + ADDR_W'(1);
                     rd_strobe_d = 1'b1;
                  end
`else
                  state_d = S_IGNORE;
`endif
               end
            end
            // The MSB is presented before the first rise; only falls that
            // follow a rise within this byte advance the shifter.
            if (fall && !is_write_q && (bit_cnt_q != 3'd0)) begin
               miso_sh_d = {miso_sh_q[6:0], 1'b0};
            end
         end

         S_IGNORE: begin
            if (rise) begin
               shift_d   = byte_val;
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (rd_cap_q) begin
         miso_sh_d = rdata;
      end

      // Deselect wins over the state transition, but only after any rise in
      // the same cycle has been processed above.
      if (cs_s && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
      end
   end

   assign address   = address_q;
   assign wdata     = wdata_q;
   assign xfc       = xfc_q;
   assign rd_strobe = rd_strobe_q;
   assign miso      = (state_q == S_DATA) && !is_write_q && miso_sh_q[7];

endmodule

// File: tb/tb_spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bridge
//
// Directed frames are driven on the SPI pins. Each stimulus step pushes the
// register-bus events it should cause (xfc with address/data, rd_strobe with
// address, miso bits) into queues; monitor processes pop and compare whenever
// the bridge presents an event. Leftover or unexpected events are mismatches.
// Build with +define+SPI_BURST_EN to select the burst-mode expectations.
// -----------------------------------------------------------------------------
module tb_spi_reg_bridge;

   localparam int unsigned SYNC = 2;
   localparam int unsigned AW   = 11;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sclk, cs_n, mosi;
   logic          miso;
   logic [7:0]    rdata = 8'h00;
   logic          rd_strobe;
   logic [AW-1:0] address;
   logic [7:0]    wdata;
   logic          xfc;

   spi_reg_bridge #(
      .SYNC_STAGES (SYNC),
      .ADDR_W      (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso),
      .rdata     (rdata),
      .rd_strobe (rd_strobe),
      .address   (address),
      .wdata     (wdata),
      .xfc       (xfc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] a;
      logic [7:0]  d;
   } xfc_t;

   xfc_t        exp_xfc[$];
   logic [10:0] exp_rd[$];
   logic        exp_miso[$];

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_rise_cyc = 0;
   bit   rd_data_phase = 1'b0;
   logic [7:0] rd_value = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Register file model: synchronous read, data valid for the one cycle
   // after rd_strobe.
   always @(posedge clk) rdata <= rd_strobe ? rd_value : 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // xfc / rd_strobe monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (xfc === 1'b1) begin
            if (exp_xfc.size() == 0) begin
               chk("xfc_unexpected", 32'd1, 32'd0);
            end else begin
               xfc_t e;
               e = exp_xfc.pop_front();
               chk("xfc_address", 32'(address), 32'(e.a));
               chk("xfc_wdata", 32'(wdata), 32'(e.d));
               chk("xfc_latency", 32'(cyc - last_rise_cyc), 32'(SYNC + 2));
            end
         end
         if (rd_strobe === 1'b1) begin
            if (exp_rd.size() == 0) begin
               chk("rd_strobe_unexpected", 32'd1, 32'd0);
            end else begin
               logic [10:0] ea;
               ea = exp_rd.pop_front();
               chk("rd_address", 32'(address), 32'(ea));
            end
         end
      end
   end

   // miso monitor: sampled where the host samples it, on the sclk pin rise
   always @(posedge sclk) begin
      if (cs_n === 1'b0 && rst_n === 1'b1) begin
         if (rd_data_phase) begin
            if (exp_miso.size() == 0) begin
               chk("miso_unexpected_bit", 32'd1, 32'd0);
            end else begin
               logic eb;
               eb = exp_miso.pop_front();
               chk("miso_read_bit", 32'(miso), 32'(eb));
            end
         end else begin
            chk("miso_idle_zero", 32'(miso), 32'd0);
         end
      end
   end

   task automatic push_xfc(input logic [10:0] a, input logic [7:0] d);
      xfc_t e;
      e.a = a;
      e.d = d;
      exp_xfc.push_back(e);
   endtask

   task automatic push_miso(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) exp_miso.push_back(v[i]);
   endtask

   // data holds up to five bytes, first byte in [39:32]. sclk half period is
   // six clk periods; pins change only on clk falling edges.
   task automatic spi_frame(input logic [39:0] data, input int nbits,
                            input bit cs_with_last, input bit keep_cs);
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         mosi = data[39-i];
         rd_data_phase = !data[39] && (i >= 16) && (i < 24);
         repeat (6) @(negedge clk);
         sclk = 1'b1;
         if ((i % 8) == 7) last_rise_cyc = cyc;
         if (cs_with_last && (i == nbits - 1)) cs_n = 1'b1;
         repeat (6) @(negedge clk);
         sclk = 1'b0;
      end
      rd_data_phase = 1'b0;
      repeat (6) @(negedge clk);
      if (!keep_cs) begin
         cs_n = 1'b1;
         repeat (12) @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      sclk  = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("reset_address", 32'(address), 32'h0);
      chk("reset_wdata", 32'(wdata), 32'h0);
      chk("reset_xfc", 32'(xfc), 32'h0);
      chk("reset_rd_strobe", 32'(rd_strobe), 32'h0);
      chk("reset_miso", 32'(miso), 32'h0);

      // Single write
      push_xfc(11'h008, 8'h15);
      spi_frame({8'h80, 8'h08, 8'h15, 16'h0}, 24, 1'b0, 1'b0);
      chk("wr1_address_hold", 32'(address), 32'h008);
      chk("wr1_wdata_hold", 32'(wdata), 32'h15);

      // Single read: 0xA5 returned MSB first
      rd_value = 8'hA5;
      exp_rd.push_back(11'h123);
      push_miso(8'hA5);
      spi_frame({8'h01, 8'h23, 8'h00, 16'h0}, 24, 1'b0, 1'b0);
      chk("rd_address_hold", 32'(address), 32'h123);
      chk("rd_wdata_untouched", 32'(wdata), 32'h15);

      // Abort after four DATA bits: address updated, wdata kept, no xfc
      spi_frame({8'h80, 8'h08, 8'hF0, 16'h0}, 20, 1'b0, 1'b0);
      chk("abort_address", 32'(address), 32'h008);
      chk("abort_wdata_kept", 32'(wdata), 32'h15);
      push_xfc(11'h008, 8'h04);
      spi_frame({8'h80, 8'h08, 8'h04, 16'h0}, 24, 1'b0, 1'b0);
      chk("after_abort_wdata", 32'(wdata), 32'h04);

      // Reset in the middle of the ADDR byte
      spi_frame({8'h87, 8'hFF, 8'h3C, 16'h0}, 12, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_address", 32'(address), 32'h0);
      chk("midrst_wdata", 32'(wdata), 32'h0);
      chk("midrst_xfc", 32'(xfc), 32'h0);
      chk("midrst_rd_strobe", 32'(rd_strobe), 32'h0);
      chk("midrst_miso", 32'(miso), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      push_xfc(11'h7FF, 8'h3C);
      spi_frame({8'h87, 8'hFF, 8'h3C, 16'h0}, 24, 1'b0, 1'b0);
      chk("postrst_address", 32'(address), 32'h7FF);
      chk("postrst_wdata", 32'(wdata), 32'h3C);

      // cs_n released together with the last DATA rise: transfer completes
      push_xfc(11'h042, 8'h99);
      spi_frame({8'h80, 8'h42, 8'h99, 16'h0}, 24, 1'b1, 1'b0);

      // Extra bytes after DATA
`ifdef SPI_BURST_EN
      push_xfc(11'h010, 8'hAA);
      push_xfc(11'h011, 8'hBB);
      push_xfc(11'h012, 8'hCC);
`else
      push_xfc(11'h010, 8'hAA);
`endif
      spi_frame({8'h80, 8'h10, 8'hAA, 8'hBB, 8'hCC}, 40, 1'b0, 1'b0);

      // Address wrap at the top of the space
`ifdef SPI_BURST_EN
      push_xfc(11'h7FF, 8'h11);
      push_xfc(11'h000, 8'h22);
`else
      push_xfc(11'h7FF, 8'h11);
`endif
      spi_frame({8'h87, 8'hFF, 8'h11, 8'h22, 8'h00}, 32, 1'b0, 1'b0);

      repeat (20) @(negedge clk);
      chk("xfc_missing", 32'(exp_xfc.size()), 32'd0);
      chk("rd_strobe_missing", 32'(exp_rd.size()), 32'd0);
      chk("miso_bits_missing", 32'(exp_miso.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
